// File: rtl/int_alu_rs.sv
// Integer ALU reservation station.
// Holds up to RS_DEPTH dispatched ALU ops, wakes their operands from the CDB,
// and issues the lowest-index ready entry each cycle to a registered ex1 stage.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    discard all entries and the pending issue
//   disp_*_rn                dispatch handshake and payload from rename
//   cdb_val/robid/data       result broadcast used for operand wakeup
//   alu_val_ex1, rs1_ex1,
//   rs2_ex1, alu_ctrl_ex1,
//   robid_ex1                registered issue to the integer ALU
module int_alu_rs #(
  parameter int unsigned DATA_LEN       = 32,
  parameter int unsigned ROB_SIZE_CLOG  = 5,
  parameter int unsigned ALU_CTRL_WIDTH = 4,
  parameter int unsigned RS_DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_val_rn,
  output logic                      disp_rdy_rn,
  input  logic [ALU_CTRL_WIDTH-1:0] disp_alu_ctrl_rn,
  input  logic [ROB_SIZE_CLOG-1:0]  disp_robid_rn,
  input  logic                      disp_rs1_rdy_rn,
  input  logic                      disp_rs2_rdy_rn,
  input  logic [DATA_LEN-1:0]       disp_rs1_data_rn,
  input  logic [DATA_LEN-1:0]       disp_rs2_data_rn,
  input  logic [ROB_SIZE_CLOG-1:0]  disp_rs1_tag_rn,
  input  logic [ROB_SIZE_CLOG-1:0]  disp_rs2_tag_rn,
  input  logic                      cdb_val,
  input  logic [ROB_SIZE_CLOG-1:0]  cdb_robid,
  input  logic [DATA_LEN-1:0]       cdb_data,
  output logic                      alu_val_ex1,
  output logic [DATA_LEN-1:0]       rs1_ex1,
  output logic [DATA_LEN-1:0]       rs2_ex1,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_ex1,
  output logic [ROB_SIZE_CLOG-1:0]  robid_ex1
);

  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Entry storage
  logic [RS_DEPTH-1:0]       valid_q;
  logic [RS_DEPTH-1:0]       rs1_rdy_q;
  logic [RS_DEPTH-1:0]       rs2_rdy_q;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_q     [RS_DEPTH];
  logic [ROB_SIZE_CLOG-1:0]  robid_q    [RS_DEPTH];
  logic [ROB_SIZE_CLOG-1:0]  rs1_tag_q  [RS_DEPTH];
  logic [ROB_SIZE_CLOG-1:0]  rs2_tag_q  [RS_DEPTH];
  logic [DATA_LEN-1:0]       rs1_data_q [RS_DEPTH];
  logic [DATA_LEN-1:0]       rs2_data_q [RS_DEPTH];

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             disp_fire;
  logic             rs1_byp;
  logic             rs2_byp;

  // A slot being issued this cycle still counts as occupied.
  assign disp_rdy_rn = ~(&valid_q);
  assign disp_fire   = disp_val_rn & disp_rdy_rn & ~flush;

  // Dispatch-time bypass of a result broadcast in the same cycle
  assign rs1_byp = ~disp_rs1_rdy_rn & cdb_val & (disp_rs1_tag_rn == cdb_robid);
  assign rs2_byp = ~disp_rs2_rdy_rn & cdb_val & (disp_rs2_tag_rn == cdb_robid);

  // Lowest-index free slot and lowest-index eligible slot; downward scan so the lowest wins
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
      if (valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
        sel_idx   = IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Entry update, wakeup and issue register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      rs1_rdy_q    <= '0;
      rs2_rdy_q    <= '0;
      alu_val_ex1  <= 1'b0;
      rs1_ex1      <= '0;
      rs2_ex1      <= '0;
      alu_ctrl_ex1 <= '0;
      robid_ex1    <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ctrl_q[i]     <= '0;
        robid_q[i]    <= '0;
        rs1_tag_q[i]  <= '0;
        rs2_tag_q[i]  <= '0;
        rs1_data_q[i] <= '0;
        rs2_data_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q     <= '0;
      alu_val_ex1 <= 1'b0;
    end else begin
      alu_val_ex1 <= sel_found;
      if (sel_found) begin
        rs1_ex1           <= rs1_data_q[sel_idx];
        rs2_ex1           <= rs2_data_q[sel_idx];
        alu_ctrl_ex1      <= ctrl_q[sel_idx];
        robid_ex1         <= robid_q[sel_idx];
        valid_q[sel_idx]  <= 1'b0;
      end

      // Wakeup of waiting operands in resident entries
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_q[i] && cdb_val) begin
          if (!rs1_rdy_q[i] && (rs1_tag_q[i] == cdb_robid)) begin
            rs1_rdy_q[i]  <= 1'b1;
            rs1_data_q[i] <= cdb_data;
          end
          if (!rs2_rdy_q[i] && (rs2_tag_q[i] == cdb_robid)) begin
            rs2_rdy_q[i]  <= 1'b1;
            rs2_data_q[i] <= cdb_data;
          end
        end
      end

      // Dispatch only targets a free slot, so it never collides with issue or wakeup
      if (disp_fire) begin
        valid_q[free_idx]    <= 1'b1;
        ctrl_q[free_idx]     <= disp_alu_ctrl_rn;
        robid_q[free_idx]    <= disp_robid_rn;
        rs1_tag_q[free_idx]  <= disp_rs1_tag_rn;
        rs2_tag_q[free_idx]  <= disp_rs2_tag_rn;
        rs1_rdy_q[free_idx]  <= disp_rs1_rdy_rn | rs1_byp;
        rs2_rdy_q[free_idx]  <= disp_rs2_rdy_rn | rs2_byp;
        rs1_data_q[free_idx] <= rs1_byp ? cdb_data : disp_rs1_data_rn;
        rs2_data_q[free_idx] <= rs2_byp ? cdb_data : disp_rs2_data_rn;
      end
    end
  end

endmodule

// File: tb/tb_int_alu_rs.sv
// Scoreboard bench for int_alu_rs: directed dispatch/wakeup/flush/reset scenarios.
module tb_int_alu_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        disp_val_rn;
  logic        disp_rdy_rn;
  logic [3:0]  disp_alu_ctrl_rn;
  logic [4:0]  disp_robid_rn;
  logic        disp_rs1_rdy_rn;
  logic        disp_rs2_rdy_rn;
  logic [31:0] disp_rs1_data_rn;
  logic [31:0] disp_rs2_data_rn;
  logic [4:0]  disp_rs1_tag_rn;
  logic [4:0]  disp_rs2_tag_rn;
  logic        cdb_val;
  logic [4:0]  cdb_robid;
  logic [31:0] cdb_data;
  logic        alu_val_ex1;
  logic [31:0] rs1_ex1;
  logic [31:0] rs2_ex1;
  logic [3:0]  alu_ctrl_ex1;
  logic [4:0]  robid_ex1;

  int total = 0;
  int bad   = 0;

  // Expected issue: {robid, ctrl, rs1, rs2}
  logic [72:0] sb_q[$];

  int_alu_rs dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .disp_val_rn      (disp_val_rn),
    .disp_rdy_rn      (disp_rdy_rn),
    .disp_alu_ctrl_rn (disp_alu_ctrl_rn),
    .disp_robid_rn    (disp_robid_rn),
    .disp_rs1_rdy_rn  (disp_rs1_rdy_rn),
    .disp_rs2_rdy_rn  (disp_rs2_rdy_rn),
    .disp_rs1_data_rn (disp_rs1_data_rn),
    .disp_rs2_data_rn (disp_rs2_data_rn),
    .disp_rs1_tag_rn  (disp_rs1_tag_rn),
    .disp_rs2_tag_rn  (disp_rs2_tag_rn),
    .cdb_val          (cdb_val),
    .cdb_robid        (cdb_robid),
    .cdb_data         (cdb_data),
    .alu_val_ex1      (alu_val_ex1),
    .rs1_ex1          (rs1_ex1),
    .rs2_ex1          (rs2_ex1),
    .alu_ctrl_ex1     (alu_ctrl_ex1),
    .robid_ex1        (robid_ex1)
  );

  always #5 clk = ~clk;

  // Monitor: every issued op must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && alu_val_ex1) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got robid=%0d rs1=%h rs2=%h, required no issue",
                 robid_ex1, rs1_ex1, rs2_ex1);
      end else begin
        logic [72:0] exp_v;
        logic [72:0] act_v;
        exp_v = sb_q.pop_front();
        act_v = {robid_ex1, alu_ctrl_ex1, rs1_ex1, rs2_ex1};
        if (act_v !== exp_v) begin
          bad++;
          $display("FAIL issue_payload: got %h, required %h", act_v, exp_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [4:0] robid, input logic [3:0] ctrl,
                      input logic [31:0] d1, input logic [31:0] d2);
    sb_q.push_back({robid, ctrl, d1, d2});
  endtask

  task automatic disp(input logic [4:0] robid, input logic [3:0] ctrl,
                      input logic r1, input logic [31:0] d1, input logic [4:0] t1,
                      input logic r2, input logic [31:0] d2, input logic [4:0] t2);
    disp_val_rn      = 1'b1;
    disp_robid_rn    = robid;
    disp_alu_ctrl_rn = ctrl;
    disp_rs1_rdy_rn  = r1;
    disp_rs1_data_rn = d1;
    disp_rs1_tag_rn  = t1;
    disp_rs2_rdy_rn  = r2;
    disp_rs2_data_rn = d2;
    disp_rs2_tag_rn  = t2;
    step();
    disp_val_rn = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] robid, input logic [31:0] data);
    cdb_val   = 1'b1;
    cdb_robid = robid;
    cdb_data  = data;
    step();
    cdb_val = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_val_rn = 1'b0; cdb_val = 1'b0;
    disp_alu_ctrl_rn = '0; disp_robid_rn = '0; disp_rs1_rdy_rn = 1'b0; disp_rs2_rdy_rn = 1'b0;
    disp_rs1_data_rn = '0; disp_rs2_data_rn = '0; disp_rs1_tag_rn = '0; disp_rs2_tag_rn = '0;
    cdb_robid = '0; cdb_data = '0;

    // Reset state
    step(); step();
    chk("rst_alu_val", 32'(alu_val_ex1), 32'd0);
    chk("rst_rs1", rs1_ex1, 32'd0);
    chk("rst_robid", 32'(robid_ex1), 32'd0);
    rst = 1'b0;
    chk("rst_disp_rdy", 32'(disp_rdy_rn), 32'd1);
    step();
    chk("idle_no_issue", 32'(alu_val_ex1), 32'd0);

    // Both ready: issue one cycle after dispatch
    push(5'd3, 4'd0, 32'd5, 32'd7);
    disp(5'd3, 4'd0, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
    chk("ready_not_same_edge", 32'(alu_val_ex1), 32'd0);
    step();
    chk("ready_issue", 32'(alu_val_ex1), 32'd1);
    chk("ready_robid", 32'(robid_ex1), 32'd3);
    step();
    chk("ready_single_issue", 32'(alu_val_ex1), 32'd0);

    // rs1 waits on tag 9, broadcast two cycles later
    push(5'd2, 4'd1, 32'h1234, 32'h11);
    disp(5'd2, 4'd1, 1'b0, 32'hdead, 5'd9, 1'b1, 32'h11, 5'd0);
    step();
    chk("wait_no_issue", 32'(alu_val_ex1), 32'd0);
    cdb(5'd9, 32'h1234);
    chk("wake_not_same_cycle", 32'(alu_val_ex1), 32'd0);
    step();
    chk("wake_issue", 32'(alu_val_ex1), 32'd1);
    chk("wake_rs1", rs1_ex1, 32'h1234);
    step();

    // Dispatch-time bypass on rs2
    push(5'd4, 4'd2, 32'h21, 32'hAA);
    cdb_val = 1'b1; cdb_robid = 5'd6; cdb_data = 32'hAA;
    disp(5'd4, 4'd2, 1'b1, 32'h21, 5'd0, 1'b0, 32'h0, 5'd6);
    cdb_val = 1'b0;
    step();
    chk("byp_issue", 32'(alu_val_ex1), 32'd1);
    chk("byp_rs2", rs2_ex1, 32'hAA);
    step();

    // Fill all entries, extra dispatch ignored, one wakeup frees a slot
    disp(5'd8,  4'd3, 1'b0, 32'h0, 5'd20, 1'b1, 32'h80, 5'd0);
    disp(5'd9,  4'd4, 1'b0, 32'h0, 5'd21, 1'b1, 32'h90, 5'd0);
    disp(5'd10, 4'd5, 1'b0, 32'h0, 5'd22, 1'b1, 32'hA0, 5'd0);
    chk("fill_rdy_partial", 32'(disp_rdy_rn), 32'd1);
    disp(5'd11, 4'd6, 1'b0, 32'h0, 5'd23, 1'b1, 32'hB0, 5'd0);
    chk("full_rdy", 32'(disp_rdy_rn), 32'd0);
    disp(5'd12, 4'd7, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    chk("full_ignore_rdy", 32'(disp_rdy_rn), 32'd0);
    push(5'd9, 4'd4, 32'h99, 32'h90);
    cdb(5'd21, 32'h99);
    chk("full_after_wake", 32'(disp_rdy_rn), 32'd0);
    step();
    chk("full_issue_robid", 32'(robid_ex1), 32'd9);
    chk("full_freed_rdy", 32'(disp_rdy_rn), 32'd1);

    // Flush with resident entries and an eligible one about to issue
    disp(5'd13, 4'd8, 1'b1, 32'h3, 5'd0, 1'b1, 32'h4, 5'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_alu_val", 32'(alu_val_ex1), 32'd0);
    chk("flush_disp_rdy", 32'(disp_rdy_rn), 32'd1);
    cdb(5'd20, 32'h5);
    cdb(5'd22, 32'h6);
    cdb(5'd23, 32'h7);
    step(); step();

    // Entries 1 and 3 woken together: lower index first
    disp(5'd16, 4'd9,  1'b0, 32'h0, 5'd30, 1'b1, 32'h160, 5'd0);
    disp(5'd17, 4'd10, 1'b0, 32'h0, 5'd31, 1'b1, 32'h170, 5'd0);
    disp(5'd18, 4'd11, 1'b0, 32'h0, 5'd29, 1'b1, 32'h180, 5'd0);
    disp(5'd19, 4'd12, 1'b0, 32'h0, 5'd31, 1'b1, 32'h190, 5'd0);
    push(5'd17, 4'd10, 32'h55, 32'h170);
    push(5'd19, 4'd12, 32'h55, 32'h190);
    cdb(5'd31, 32'h55);
    chk("prio_no_issue_yet", 32'(alu_val_ex1), 32'd0);
    step();
    chk("prio_first", 32'(robid_ex1), 32'd17);
    step();
    chk("prio_second", 32'(robid_ex1), 32'd19);
    push(5'd16, 4'd9,  32'h66, 32'h160);
    push(5'd18, 4'd11, 32'h77, 32'h180);
    cdb(5'd30, 32'h66);
    cdb(5'd29, 32'h77);
    step(); step();

    // Reset mid-operation discards a pending issue
    disp(5'd25, 4'd13, 1'b1, 32'h8, 5'd0, 1'b1, 32'h9, 5'd0);
    rst = 1'b1;
    #1;
    chk("midrst_alu_val", 32'(alu_val_ex1), 32'd0);
    step();
    rst = 1'b0;
    chk("midrst_disp_rdy", 32'(disp_rdy_rn), 32'd1);
    step();
    chk("midrst_no_issue", 32'(alu_val_ex1), 32'd0);
    step(); step();

    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_alu_rs.md
INT_ALU_RS -- requirements
Module: int_alu_rs

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, operand/result width.
REQ-002 SHALL have parameter ROB_SIZE_CLOG, default 5, ROB id / tag width.
REQ-003 SHALL have parameter ALU_CTRL_WIDTH, default 4, ALU op encoding width.
REQ-004 SHALL have parameter RS_DEPTH, default 4, number of station entries (power of 2, >=2).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: flush  in  1  discard all entries and the pending issue.
REQ-007 SHALL have ports: disp_val_rn  in  1  dispatch request; disp_rdy_rn  out  1  station can accept.
REQ-008 SHALL have ports: disp_alu_ctrl_rn  in  ALU_CTRL_WIDTH; disp_robid_rn  in  ROB_SIZE_CLOG  destination ROB id.
REQ-009 SHALL have ports: disp_rs1_rdy_rn / disp_rs2_rdy_rn  in  1  operand value present; disp_rs1_data_rn / disp_rs2_data_rn  in  DATA_LEN; disp_rs1_tag_rn / disp_rs2_tag_rn  in  ROB_SIZE_CLOG  producer ROB id when not ready.
REQ-010 SHALL have ports: cdb_val  in  1; cdb_robid  in  ROB_SIZE_CLOG; cdb_data  in  DATA_LEN  result broadcast.
REQ-011 SHALL have ports: alu_val_ex1  out  1; rs1_ex1, rs2_ex1  out  DATA_LEN; alu_ctrl_ex1  out  ALU_CTRL_WIDTH; robid_ex1  out  ROB_SIZE_CLOG  registered issue to the integer ALU.

Function
REQ-012 SHALL hold per entry: valid, alu_ctrl, robid, and per operand rdy, tag, data.
REQ-013 SHALL drive disp_rdy_rn = 1 iff at least one entry is invalid at the start of the cycle; an entry issued in the same cycle does not count as free.
REQ-014 SHALL, on disp_val_rn & disp_rdy_rn & !flush, write the lowest-index invalid entry; disp_val_rn with disp_rdy_rn=0 is ignored, no state change.
REQ-015 SHALL, on dispatch of a not-ready operand whose tag equals cdb_robid with cdb_val=1 that cycle, store cdb_data and set rdy (dispatch-time bypass).
REQ-016 SHALL, each cycle with cdb_val=1, for every valid entry operand with rdy=0 and tag==cdb_robid, capture cdb_data and set rdy at the next edge.
REQ-017 SHALL treat an entry as eligible when valid and both rdy bits are set at the start of the cycle; operands woken this cycle are eligible next cycle (no same-cycle wakeup-to-select).
REQ-018 SHALL select the lowest-index eligible entry each cycle, clear its valid at the next edge, and register its fields onto the ex1 outputs with alu_val_ex1=1.
REQ-019 SHALL drive alu_val_ex1=0 in any cycle following a cycle with no eligible entry; the data outputs then hold their previous values.
REQ-020 SHALL give issue latency of 1 cycle: an entry dispatched fully ready at edge N is eligible in cycle N and appears with alu_val_ex1=1 after edge N+1 if it wins select.
REQ-021 SHALL issue at most one entry per cycle; non-selected eligible entries retain state.
REQ-022 SHALL, on flush=1, clear all valid bits and force alu_val_ex1=0 at the next edge; dispatch and CDB capture in that cycle are discarded; flush has priority over all other updates.
REQ-023 SHALL never drop or duplicate an instruction: each accepted dispatch issues exactly once unless flushed.

Reset
REQ-024 SHALL, while rst=1, asynchronously clear all entry valid and rdy bits, alu_val_ex1, rs1_ex1, rs2_ex1, alu_ctrl_ex1, robid_ex1 to 0; disp_rdy_rn reads 1 once reset deasserts.
REQ-025 SHALL, on reset asserted mid-operation, discard all entries and the pending issue; no issue occurs on the first edge after deassertion.

Verification
REQ-026 SHALL cover: dispatch robid=3, both operands ready (5, 7), ADD ctrl -> next cycle alu_val_ex1=1, rs1_ex1=5, rs2_ex1=7, robid_ex1=3.
REQ-027 SHALL cover: dispatch robid=2 with rs1 tag=9 not ready; CDB robid=9 data=0x1234 two cycles later -> issue one cycle after capture with rs1_ex1=0x1234.
REQ-028 SHALL cover: dispatch with rs2 tag=6 while cdb_val=1, cdb_robid=6, cdb_data=0xAA -> entry eligible next cycle, rs2_ex1=0xAA.
REQ-029 SHALL cover: fill all RS_DEPTH entries with unready operands -> disp_rdy_rn=0, extra disp_val_rn ignored; after one wakeup and issue, disp_rdy_rn=1 the following cycle.
REQ-030 SHALL cover: entries 1 and 3 eligible same cycle -> entry 1 issues first, entry 3 next cycle.
REQ-031 SHALL cover: flush with 3 valid entries and an eligible entry -> alu_val_ex1=0 next cycle, disp_rdy_rn=1, no later issue of flushed robids.
